// File: rtl/mycpu_pkg.sv
// -----------------------------------------------------------------------------
// mycpu_pkg
// Shared type definitions for the mycpu pipeline: memory argument bundle from
// decode, data-bus request/response structs, and the memory-access-unit FSM
// state encoding. Also provides the alignment predicate used when the
// MEM_ALIGN_CHECK_EN build option is enabled.
// -----------------------------------------------------------------------------
package mycpu_pkg;

    // Access width of a load/store.
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    // Extension applied to sub-word load data.
    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } sig_t;

    // Memory arguments produced by the decode-side generator.
    typedef struct packed {
        logic   valid;   // instruction accesses memory
        logic   write;   // store when 1, load when 0
        sig_t   sig;
        msize_t msize;
    } memory_args_t;

    // Data-bus request.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    // Data-bus response.
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    // Memory access unit FSM states.
    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_ADDR = 2'd1,
        MAU_DATA = 2'd2,
        MAU_DONE = 2'd3
    } mau_state_t;

    // True when an access of the given size is not naturally aligned.
    function automatic logic is_misaligned(input msize_t msize, input logic [1:0] addr_lo);
        case (msize)
            MSIZE2:  return addr_lo[0];
            MSIZE4:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load-data extraction: picks the addressed byte or halfword
// out of the bus word and sign- or zero-extends it to 32 bits. Words pass
// through unchanged.
//
// Ports:
//   data    in  32  raw bus read data
//   addr    in  2   low address bits selecting the lane
//   msize   in      access width
//   sig     in      SIGNED -> sign-extend, UNSIGNED -> zero-extend
//   result  out 32  aligned, extended load value
// -----------------------------------------------------------------------------
module load_align
    import mycpu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  msize_t      msize,
    input  sig_t        sig,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        byte_sel = data[7:0];
        case (addr)
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            2'd3:    byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase

        half_sel = addr[1] ? data[31:16] : data[15:0];

        result = data;
        case (msize)
            MSIZE1:  result = {{24{(sig == SIGNED) & byte_sel[7]}}, byte_sel};
            MSIZE2:  result = {{16{(sig == SIGNED) & half_sel[15]}}, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// -----------------------------------------------------------------------------
// memory_access_unit
// Memory stage of the mycpu pipeline. Accepts one instruction at a time,
// issues at most one data-bus transaction, aligns/extends load data and holds
// a single result word for writeback until it is consumed.
//
// Build option:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word accesses raise
//                       an address-error exception without touching the bus.
//                       When undefined, out_exc/out_badvaddr are tied to 0.
//
// Ports:
//   clk           in       clock, rising edge
//   reset         in       synchronous active-high reset
//   in_valid      in       upstream instruction presented
//   in_ready      out      unit accepts this cycle (IDLE only)
//   in_args       in       memory_args_t from decode
//   in_addr       in  32   effective address
//   in_wdata      in  32   store source value
//   dreq          out      data-bus request (dbus_req_t)
//   dresp         in       data-bus response (dbus_resp_t)
//   out_valid     out      result held for writeback
//   out_ready     in       writeback consumes the result
//   out_data      out 32   load value / in_addr for non-memory ops / 0 for stores
//   out_exc       out      address-error exception
//   out_badvaddr  out 32   faulting address
// -----------------------------------------------------------------------------
module memory_access_unit
    import mycpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  memory_args_t in_args,
    input  logic [31:0]  in_addr,
    input  logic [31:0]  in_wdata,
    output dbus_req_t    dreq,
    input  dbus_resp_t   dresp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_exc,
    output logic [31:0]  out_badvaddr
);

    mau_state_t  state, state_next;

    logic        accept;
    logic        in_misaligned;
    logic        bus_done;

    // Captured instruction.
    logic        write_q;
    sig_t        sig_q;
    msize_t      msize_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [3:0]  strobe;
    logic [31:0] wdata_lanes;
    logic [31:0] load_result;

    // in_ready is forced low while reset is held so nothing slips in on the
    // reset edge.
    assign in_ready = (state == MAU_IDLE) && !reset;
    assign accept   = in_valid && in_ready;

`ifdef MEM_ALIGN_CHECK_EN
    assign in_misaligned = is_misaligned(in_args.msize, in_addr[1:0]);
`else
    assign in_misaligned = 1'b0;
`endif

    // Bus transaction completes either with both handshakes in the ADDR cycle
    // or with data_ok later while waiting in DATA.
    assign bus_done = ((state == MAU_ADDR) && dresp.addr_ok && dresp.data_ok) ||
                      ((state == MAU_DATA) && dresp.data_ok);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (reset) begin
            state <= MAU_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MAU_IDLE: begin
                if (accept) begin
                    if (!in_args.valid || in_misaligned) begin
                        state_next = MAU_DONE;
                    end else begin
                        state_next = MAU_ADDR;
                    end
                end
            end
            MAU_ADDR: begin
                if (dresp.addr_ok) begin
                    state_next = dresp.data_ok ? MAU_DONE : MAU_DATA;
                end
            end
            MAU_DATA: begin
                if (dresp.data_ok) begin
                    state_next = MAU_DONE;
                end
            end
            MAU_DONE: begin
                if (out_ready) begin
                    state_next = MAU_IDLE;
                end
            end
            default: state_next = MAU_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction capture
    // ------------------------------------------------------------------
    // NOTE: the payload registers carry no reset; they are only observed
    // on the bus while state is ADDR, which is reachable only after a
    // capture has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= in_args.write;
            sig_q   <= in_args.sig;
            msize_q <= in_args.msize;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Bus request: everything derives from captured registers and state,
    // so the request is stable for as long as the FSM sits in ADDR.
    // ------------------------------------------------------------------
    always_comb begin
        strobe      = 4'b1111;
        wdata_lanes = wdata_q;
        case (msize_q)
            MSIZE1: begin
                strobe      = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            MSIZE2: begin
                strobe      = 4'b0011 << {addr_q[1], 1'b0};
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                strobe      = 4'b1111;
                wdata_lanes = wdata_q;
            end
        endcase
        if (!write_q) begin
            strobe = 4'b0000;
        end
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = (state == MAU_ADDR);
        dreq.addr   = addr_q;
        dreq.size   = msize_q;
        dreq.strobe = strobe;
        dreq.data   = wdata_lanes;
    end

    // ------------------------------------------------------------------
    // Load alignment and result register
    // ------------------------------------------------------------------
    load_align u_load_align (
        .data   (dresp.data),
        .addr   (addr_q[1:0]),
        .msize  (msize_q),
        .sig    (sig_q),
        .result (load_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
        end else if (accept) begin
            if (!in_args.valid) begin
                out_data <= in_addr;
            end else if (in_misaligned) begin
                out_data <= '0;
            end
        end else if (bus_done) begin
            out_data <= write_q ? 32'd0 : load_result;
        end
    end

    assign out_valid = (state == MAU_DONE);

`ifdef MEM_ALIGN_CHECK_EN
    logic        exc_q;
    logic [31:0] badvaddr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q      <= 1'b0;
            badvaddr_q <= '0;
        end else if (accept) begin
            exc_q      <= in_args.valid && in_misaligned;
            badvaddr_q <= (in_args.valid && in_misaligned) ? in_addr : 32'd0;
        end
    end

    assign out_exc      = exc_q;
    assign out_badvaddr = badvaddr_q;
`else
    assign out_exc      = 1'b0;
    assign out_badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_access_unit
// Directed self-checking bench for memory_access_unit. The bench plays the
// role of both the upstream stage and the data bus. Inputs change 1 ns after
// the rising edge and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_memory_access_unit;
    import mycpu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    memory_args_t in_args;
    logic [31:0]  in_addr;
    logic [31:0]  in_wdata;
    dbus_req_t    dreq;
    dbus_resp_t   dresp;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_exc;
    logic [31:0]  out_badvaddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_args      (in_args),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .dreq         (dreq),
        .dresp        (dresp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_exc      (out_exc),
        .out_badvaddr (out_badvaddr)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accepting edge.
    task automatic issue(input logic valid, input logic write, input sig_t sig,
                         input msize_t msize, input logic [31:0] addr, input logic [31:0] wdata);
        in_valid = 1'b1;
        in_args  = '{valid: valid, write: write, sig: sig, msize: msize};
        in_addr  = addr;
        in_wdata = wdata;
        step();
        in_valid = 1'b0;
    endtask

    task automatic bus_idle();
        dresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 32'd0};
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Load whose bus responds with both handshakes in the first ADDR cycle.
    task automatic fast_load(input string tag, input sig_t sig, input msize_t msize,
                             input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [31:0] expected);
        issue(1'b1, 1'b0, sig, msize, addr, 32'd0);
        check({tag, "_dreq_valid"}, 32'(dreq.valid), 32'd1);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: rdata};
        step();
        bus_idle();
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_data"}, out_data, expected);
        handoff(tag);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_args   = '0;
        in_addr   = 32'd0;
        in_wdata  = 32'd0;
        out_ready = 1'b0;
        bus_idle();

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dreq_valid", 32'(dreq.valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_exc", 32'(out_exc), 32'd0);
        check("rst_badvaddr", out_badvaddr, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- LB 0x1003, both oks in first ADDR cycle ----------------
        issue(1'b1, 1'b0, SIGNED, MSIZE1, 32'h0000_1003, 32'd0);
        check("lb_dreq_valid", 32'(dreq.valid), 32'd1);
        check("lb_dreq_addr", dreq.addr, 32'h0000_1003);
        check("lb_dreq_size", 32'(dreq.size), 32'(MSIZE1));
        check("lb_dreq_strobe", 32'(dreq.strobe), 32'd0);
        check("lb_in_ready", 32'(in_ready), 32'd0);
        check("lb_out_valid_n1", 32'(out_valid), 32'd0);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h80AA_55CC};
        step();
        bus_idle();
        check("lb_out_valid_n2", 32'(out_valid), 32'd1);
        check("lb_out_data", out_data, 32'hFFFF_FF80);
        check("lb_dreq_dropped", 32'(dreq.valid), 32'd0);
        handoff("lb");

        // ---------------- LHU 0x1002, addr_ok cycle 1, data_ok cycle 3 ----------------
        issue(1'b1, 1'b0, UNSIGNED, MSIZE2, 32'h0000_1002, 32'd0);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'd0};
        step();
        bus_idle();
        check("lhu_data_dreq_valid", 32'(dreq.valid), 32'd0);
        check("lhu_data_out_valid", 32'(out_valid), 32'd0);
        step();
        check("lhu_wait_out_valid", 32'(out_valid), 32'd0);
        dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h8001_1234};
        step();
        bus_idle();
        check("lhu_out_valid", 32'(out_valid), 32'd1);
        check("lhu_out_data", out_data, 32'h0000_8001);
        handoff("lhu");

        // ---------------- LW with address stall: request stays stable ----------------
        issue(1'b1, 1'b0, SIGNED, MSIZE4, 32'h0000_1004, 32'd0);
        step();
        check("lw_stall_dreq_valid", 32'(dreq.valid), 32'd1);
        check("lw_stall_dreq_addr", dreq.addr, 32'h0000_1004);
        check("lw_stall_dreq_size", 32'(dreq.size), 32'(MSIZE4));
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'hDEAD_BEEF};
        step();
        bus_idle();
        check("lw_out_data", out_data, 32'hDEAD_BEEF);
        handoff("lw");

        // ---------------- more extraction patterns ----------------
        fast_load("lh", SIGNED, MSIZE2, 32'h0000_1000, 32'h1234_F00D, 32'hFFFF_F00D);
        fast_load("lbu", UNSIGNED, MSIZE1, 32'h0000_1001, 32'h80AA_55CC, 32'h0000_0055);
        fast_load("lbu_hi", UNSIGNED, MSIZE1, 32'h0000_1003, 32'h80AA_55CC, 32'h0000_0080);

        // ---------------- SB 0x2001 ----------------
        issue(1'b1, 1'b1, UNSIGNED, MSIZE1, 32'h0000_2001, 32'h0000_00AB);
        check("sb_dreq_valid", 32'(dreq.valid), 32'd1);
        check("sb_strobe", 32'(dreq.strobe), 32'b0010);
        check("sb_dreq_data", dreq.data, 32'hABAB_ABAB);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h5555_5555};
        step();
        bus_idle();
        check("sb_out_valid", 32'(out_valid), 32'd1);
        check("sb_out_data", out_data, 32'd0);
        handoff("sb");

        // ---------------- SH 0x2002 ----------------
        issue(1'b1, 1'b1, UNSIGNED, MSIZE2, 32'h0000_2002, 32'h1234_CDEF);
        check("sh_strobe", 32'(dreq.strobe), 32'b1100);
        check("sh_dreq_data", dreq.data, 32'hCDEF_CDEF);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'd0};
        step();
        bus_idle();
        check("sh_out_data", out_data, 32'd0);
        handoff("sh");

        // ---------------- non-memory op held by out_ready low ----------------
        issue(1'b0, 1'b0, UNSIGNED, MSIZE4, 32'h0000_1234, 32'd0);
        check("nm_out_valid_n1", 32'(out_valid), 32'd1);
        check("nm_out_data", out_data, 32'h0000_1234);
        check("nm_dreq_valid", 32'(dreq.valid), 32'd0);
        // A competing instruction is offered while the result is held.
        in_valid = 1'b1;
        in_args  = '{valid: 1'b0, write: 1'b0, sig: UNSIGNED, msize: MSIZE4};
        in_addr  = 32'h0000_5555;
        for (int i = 0; i < 3; i++) begin
            check("nm_hold_in_ready", 32'(in_ready), 32'd0);
            step();
            check("nm_hold_out_valid", 32'(out_valid), 32'd1);
            check("nm_hold_out_data", out_data, 32'h0000_1234);
        end
        in_valid = 1'b0;
        handoff("nm");

        // ---------------- SW 0x3002 (misaligned word) ----------------
        issue(1'b1, 1'b1, UNSIGNED, MSIZE4, 32'h0000_3002, 32'h0BAD_F00D);
`ifdef MEM_ALIGN_CHECK_EN
        check("sw_mis_dreq_valid", 32'(dreq.valid), 32'd0);
        check("sw_mis_out_valid", 32'(out_valid), 32'd1);
        check("sw_mis_out_exc", 32'(out_exc), 32'd1);
        check("sw_mis_badvaddr", out_badvaddr, 32'h0000_3002);
        check("sw_mis_out_data", out_data, 32'd0);
`else
        check("sw_mis_dreq_valid", 32'(dreq.valid), 32'd1);
        check("sw_mis_strobe", 32'(dreq.strobe), 32'b1111);
        check("sw_mis_dreq_data", dreq.data, 32'h0BAD_F00D);
        check("sw_mis_dreq_addr", dreq.addr, 32'h0000_3002);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'd0};
        step();
        bus_idle();
        check("sw_mis_out_valid", 32'(out_valid), 32'd1);
        check("sw_mis_out_exc", 32'(out_exc), 32'd0);
        check("sw_mis_out_data", out_data, 32'd0);
`endif
        handoff("sw");

        // ---------------- reset while in DATA ----------------
        issue(1'b1, 1'b0, SIGNED, MSIZE4, 32'h0000_1000, 32'd0);
        dresp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'd0};
        step();
        bus_idle();
        check("rst_data_dreq_valid_pre", 32'(dreq.valid), 32'd0);
        reset = 1'b1;
        step();
        check("rst_data_dreq_valid", 32'(dreq.valid), 32'd0);
        check("rst_data_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_in_ready_held", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_data_in_ready", 32'(in_ready), 32'd1);
        step();
        check("rst_data_stays_idle", 32'(out_valid), 32'd0);
        check("rst_data_no_req", 32'(dreq.valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the mycpu pipeline. Consumes the `memory_args_t` produced by the decode-side memory-argument generator together with the execute-stage address and store data. Issues at most one data-bus transaction, aligns and extends load data, and hands a single result word to writeback through a valid/ready handshake.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: an upstream instruction is presented.
- `in_ready` out 1: the unit accepts it this cycle; high only in IDLE.
- `in_args` in `memory_args_t`: valid/write/sig/msize from decode.
- `in_addr` in 32: effective address (ALU result).
- `in_wdata` in 32: store source register value.
- `dreq` out `dbus_req_t`: valid, addr, size, strobe, data.
- `dresp` in `dbus_resp_t`: addr_ok, data_ok, data.
- `out_valid` out 1: result held for writeback.
- `out_ready` in 1: writeback consumes the result.
- `out_data` out 32: load result, `in_addr` for non-memory ops, 0 for stores.
- `out_exc` out 1: address-error exception.
- `out_badvaddr` out 32: faulting address.

## Operation
- Capture on `in_valid && in_ready`: args, addr, wdata into registers.
- FSM states IDLE, ADDR, DATA, DONE; reset → IDLE.
  - IDLE → ADDR: memory op accepted.
  - IDLE → DONE: non-memory op accepted (`in_args.valid=0`), or misaligned memory op (macro on).
  - ADDR: `dreq.valid=1`. On `addr_ok && data_ok` → DONE. On `addr_ok` alone → DATA.
  - DATA: `dreq.valid=0`. On `data_ok` → DONE.
  - DONE: `out_valid=1`. On `out_ready` → IDLE.
- `dreq.valid`, addr, size, strobe and data are stable while in ADDR.
- `dreq.addr`: captured address. `dreq.size`: captured `msize`.
- Store strobe:
  - MSIZE1: `4'b0001 << addr[1:0]`.
  - MSIZE2: `4'b0011 << {addr[1],1'b0}`.
  - MSIZE4: `4'b1111`.
  - Loads: 0.
- Store data: the byte or halfword is replicated across all lanes; words pass through unchanged.
- Load data: select byte `addr[1:0]` or halfword `addr[1]` from `dresp.data`. Sign-extend when `sig==SIGNED`, zero-extend otherwise. Register the result on `data_ok`.
- Reset values: `in_ready=0` during reset and 1 afterwards (IDLE), `out_valid=0`, `dreq.valid=0`, `out_data=0`, `out_exc=0`, `out_badvaddr=0`.
- Reset mid-transaction: return to IDLE and drop the request. The bus interface shares the same reset, so no stale `data_ok` is expected.

## Timing
- Accept at edge N. `dreq.valid` is registered and asserted in cycle N+1.
- Best-case load: `addr_ok` and `data_ok` both in N+1 → `out_valid` in N+2. Total latency 2 cycles; throughput one instruction per 3 cycles.
- Non-memory op: `out_valid` in N+1.
- `data_ok` arriving in the same cycle as `addr_ok` is legal and skips DATA.
- `out_valid` with `out_ready` low: hold all outputs unchanged. A new input is not accepted until DONE exits; the earliest new accept is the cycle after the handoff.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned cases are MSIZE2 with `addr[0]`, and MSIZE4 with `addr[1:0]!=0`.
  - A misaligned access goes IDLE → DONE with no bus request, `out_exc=1`, `out_badvaddr=addr`, `out_data=0`.
- Undefined:
  - `out_exc` and `out_badvaddr` are tied to 0.
  - Misaligned accesses are issued as-is; strobe and extraction use the formulas above.

## Structure
- `mau_state_t` (IDLE/ADDR/DATA/DONE) goes in the shared mycpu package.
- The package already holds `memory_args_t`, `msize_t`, `sig_t`, `dbus_req_t` and `dbus_resp_t`.
- One sub-module, `load_align`: combinational extraction and extension from (data, addr[1:0], msize, sig).

## Test plan
- LB at `0x1003`, bus data `0x80AA55CC`, both oks in the first ADDR cycle → `out_data=0xFFFFFF80`, `out_valid` 2 cycles after accept.
- LHU at `0x1002`, data `0x8001_1234`, `addr_ok` cycle 1, `data_ok` cycle 3 → `out_data=0x00008001` after passing through DATA.
- SB at `0x2001`, wdata `0x000000AB` → `strobe=4'b0010`, `dreq.data=0xABABABAB`, `out_data=0`.
- Non-memory op with `in_addr=0x1234` and `out_ready` low for 3 cycles → `out_valid` held, `out_data=0x1234`, `in_ready=0` throughout.
- SW at `0x3002` (macro on) → `dreq.valid` never asserted, `out_exc=1`, `out_badvaddr=0x3002`. Macro off → `strobe=4'b1111` and the request is issued.
- Reset asserted while in DATA → next cycle: IDLE, `dreq.valid=0`, `out_valid=0`, `in_ready=1` after reset deasserts.
